// File: rtl/store_commit_unit.sv
// store_commit_unit
//   Responder end of the store-buffer -> cache store port. Accepts one committed
//   store at a time. Cacheable stores do a tag lookup and, on a hit, a byte-masked
//   write into the L1 D-cache (write-through, no-write-allocate); every store,
//   cacheable or IO, is then written to the memory bus. cache_done_o pulses for one
//   cycle when the store has fully completed.
//
//   Ports
//     cpu_clk_i, cpu_rst_ni        clock, asynchronous active-low reset
//     store_*_i                    store request; held stable until cache_done_o
//     cache_done_o                 1-cycle completion pulse
//     dc_busy_i                    refill engine owns the tag/data arrays this cycle
//     tag_rd_*                     tag array read port (data returns one cycle later)
//     dc_wr_*                      data array write port
//     mem_*                        bus write port (req held until gnt, then wait for ack)
//
//   Optional feature macro: STORE_BUS_ERR_EN
//     Adds mem_err_i (qualifies mem_ack_i), store_fault_o (pulse with cache_done_o)
//     and store_fault_addr_o (address of the last faulting store).
module store_commit_unit #(
  parameter int PHYS       = 32,
  parameter int WORDS_LOG2 = 3,
  parameter int SETS_LOG2  = 6,
  localparam int TAGW      = PHYS - 2 - WORDS_LOG2 - SETS_LOG2
) (
  input  logic                            cpu_clk_i,
  input  logic                            cpu_rst_ni,
  input  logic [PHYS-3:0]                 store_address_i,
  input  logic [31:0]                     store_data_i,
  input  logic [3:0]                      store_bm_i,
  input  logic                            store_io_i,
  input  logic                            store_valid_i,
  output logic                            cache_done_o,
  input  logic                            dc_busy_i,
  output logic                            tag_rd_en_o,
  output logic [SETS_LOG2-1:0]            tag_rd_index_o,
  input  logic [TAGW-1:0]                 tag_rd_tag_i,
  input  logic                            tag_rd_vld_i,
  output logic                            dc_wr_en_o,
  output logic [SETS_LOG2+WORDS_LOG2-1:0] dc_wr_index_o,
  output logic [31:0]                     dc_wr_data_o,
  output logic [3:0]                      dc_wr_bm_o,
  output logic                            mem_req_o,
  output logic [PHYS-3:0]                 mem_addr_o,
  output logic [31:0]                     mem_data_o,
  output logic [3:0]                      mem_bm_o,
  output logic                            mem_io_o,
  input  logic                            mem_gnt_i,
  input  logic                            mem_ack_i
`ifdef STORE_BUS_ERR_EN
  ,
  input  logic                            mem_err_i,
  output logic                            store_fault_o,
  output logic [PHYS-3:0]                 store_fault_addr_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    TAGRD,
    LOOKUP,
    BUS,
    WAITACK,
    DONE
  } state_t;

  state_t state, state_next;

  logic [PHYS-3:0] addr_q;
  logic [31:0]     data_q;
  logic [3:0]      bm_q;
  logic            io_q;
  logic            hit;

  assign hit = tag_rd_vld_i && (tag_rd_tag_i == addr_q[PHYS-3 -: TAGW]);

  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      bm_q   <= '0;
      io_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && store_valid_i) begin
        addr_q <= store_address_i;
        data_q <= store_data_i;
        bm_q   <= store_bm_i;
        io_q   <= store_io_i;
      end
    end
  end

  always_comb begin
    state_next   = state;
    tag_rd_en_o  = 1'b0;
    dc_wr_en_o   = 1'b0;
    mem_req_o    = 1'b0;
    cache_done_o = 1'b0;
    case (state)
      IDLE: begin
        if (store_valid_i) state_next = store_io_i ? BUS : TAGRD;
      end
      TAGRD: begin
        tag_rd_en_o = !dc_busy_i;
        if (!dc_busy_i) state_next = LOOKUP;
      end
      LOOKUP: begin
        // A hit while the refill engine owns the arrays must not write: the
        // line may be mid-refill, so the whole lookup is redone instead.
        if (hit) begin
          if (dc_busy_i) begin
            state_next = TAGRD;
          end else begin
            dc_wr_en_o = 1'b1;
            state_next = BUS;
          end
        end else begin
          state_next = BUS;
        end
      end
      BUS: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_next = mem_ack_i ? DONE : WAITACK;
      end
      WAITACK: begin
        if (mem_ack_i) state_next = DONE;
      end
      DONE: begin
        cache_done_o = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Payload outputs are zero unless their strobe is active.
  assign tag_rd_index_o = tag_rd_en_o ? addr_q[WORDS_LOG2 +: SETS_LOG2] : '0;
  assign dc_wr_index_o  = dc_wr_en_o ? addr_q[WORDS_LOG2+SETS_LOG2-1:0] : '0;
  assign dc_wr_data_o   = dc_wr_en_o ? data_q : '0;
  assign dc_wr_bm_o     = dc_wr_en_o ? bm_q : '0;
  assign mem_addr_o     = mem_req_o ? addr_q : '0;
  assign mem_data_o     = mem_req_o ? data_q : '0;
  assign mem_bm_o       = mem_req_o ? bm_q : '0;
  assign mem_io_o       = mem_req_o ? io_q : 1'b0;

`ifdef STORE_BUS_ERR_EN
  logic            ack_taken;
  logic            err_q;
  logic [PHYS-3:0] fault_addr_q;

  // An ack only counts in BUS when it arrives together with the grant.
  assign ack_taken = ((state == BUS) && mem_gnt_i && mem_ack_i) ||
                     ((state == WAITACK) && mem_ack_i);

  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      err_q        <= 1'b0;
      fault_addr_q <= '0;
    end else if (state == IDLE) begin
      err_q <= 1'b0;
    end else if (ack_taken && mem_err_i) begin
      err_q        <= 1'b1;
      fault_addr_q <= addr_q;
    end
  end

  assign store_fault_o      = (state == DONE) && err_q;
  assign store_fault_addr_o = fault_addr_q;
`endif

endmodule

// File: tb/tb_store_commit_unit.sv
`timescale 1ns/1ps
module tb_store_commit_unit;
  localparam int PHYS = 32;
  localparam int WL   = 3;
  localparam int SL   = 6;
  localparam int TAGW = PHYS - 2 - WL - SL;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [PHYS-3:0]   store_address_i = '0;
  logic [31:0]       store_data_i = '0;
  logic [3:0]        store_bm_i = '0;
  logic              store_io_i = 1'b0;
  logic              store_valid_i = 1'b0;
  logic              cache_done_o;
  logic              dc_busy_i = 1'b0;
  logic              tag_rd_en_o;
  logic [SL-1:0]     tag_rd_index_o;
  logic [TAGW-1:0]   tag_rd_tag_i = '0;
  logic              tag_rd_vld_i = 1'b0;
  logic              dc_wr_en_o;
  logic [SL+WL-1:0]  dc_wr_index_o;
  logic [31:0]       dc_wr_data_o;
  logic [3:0]        dc_wr_bm_o;
  logic              mem_req_o;
  logic [PHYS-3:0]   mem_addr_o;
  logic [31:0]       mem_data_o;
  logic [3:0]        mem_bm_o;
  logic              mem_io_o;
  logic              mem_gnt_i = 1'b0;
  logic              mem_ack_i = 1'b0;
`ifdef STORE_BUS_ERR_EN
  logic              mem_err_i = 1'b0;
  logic              store_fault_o;
  logic [PHYS-3:0]   store_fault_addr_o;
  logic              err_force = 1'b0;
`endif

  always #5 clk = ~clk;

  store_commit_unit #(.PHYS(PHYS), .WORDS_LOG2(WL), .SETS_LOG2(SL)) dut (
    .cpu_clk_i(clk), .cpu_rst_ni(rst_n),
    .store_address_i(store_address_i), .store_data_i(store_data_i),
    .store_bm_i(store_bm_i), .store_io_i(store_io_i), .store_valid_i(store_valid_i),
    .cache_done_o(cache_done_o), .dc_busy_i(dc_busy_i),
    .tag_rd_en_o(tag_rd_en_o), .tag_rd_index_o(tag_rd_index_o),
    .tag_rd_tag_i(tag_rd_tag_i), .tag_rd_vld_i(tag_rd_vld_i),
    .dc_wr_en_o(dc_wr_en_o), .dc_wr_index_o(dc_wr_index_o),
    .dc_wr_data_o(dc_wr_data_o), .dc_wr_bm_o(dc_wr_bm_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_bm_o(mem_bm_o), .mem_io_o(mem_io_o),
    .mem_gnt_i(mem_gnt_i), .mem_ack_i(mem_ack_i)
`ifdef STORE_BUS_ERR_EN
    , .mem_err_i(mem_err_i), .store_fault_o(store_fault_o),
    .store_fault_addr_o(store_fault_addr_o)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen at cycle %0d, none expected", name, cyc);
  endtask

  // ---------------- reference model: tag array contents and expected traffic
  logic [TAGW-1:0] tag_mem [64];
  logic            vld_mem [64];

  typedef struct { logic [SL+WL-1:0] idx; logic [31:0] data; logic [3:0] bm; } dc_exp_t;
  typedef struct { logic [PHYS-3:0] addr; logic [31:0] data; logic [3:0] bm; logic io; int reqc; } mem_exp_t;
  typedef struct { logic [PHYS-3:0] addr; logic io; int accept; int lat; logic err; } done_exp_t;

  dc_exp_t   dc_q[$];
  mem_exp_t  mem_q[$];
  done_exp_t done_q[$];

  // ---------------- environment: tag array, refill-busy and bus responder
  int   gnt_dly = 0;
  int   ack_dly = 0;
  logic busy_force = 1'b0;
  logic busy_rand = 1'b0;
  int   bfm_req_cnt = 0;
  int   bfm_ack_cnt = 0;
  logic bfm_ack_pend = 1'b0;
  logic was_rd;
  logic [SL-1:0] rd_idx;

  always @(posedge clk) begin
    was_rd = tag_rd_en_o;
    rd_idx = tag_rd_index_o;
    #2;
    if (was_rd) begin
      tag_rd_tag_i = tag_mem[rd_idx];
      tag_rd_vld_i = vld_mem[rd_idx];
    end else begin
      tag_rd_tag_i = TAGW'($urandom);
      tag_rd_vld_i = 1'($urandom);
    end
    dc_busy_i = busy_force | (busy_rand & ($urandom_range(0, 3) == 0));
    mem_gnt_i = 1'b0;
    mem_ack_i = 1'b0;
`ifdef STORE_BUS_ERR_EN
    mem_err_i = 1'b0;
`endif
    if (!rst_n) begin
      bfm_ack_pend = 1'b0;
      bfm_req_cnt  = 0;
    end else if (bfm_ack_pend) begin
      if (bfm_ack_cnt >= ack_dly) begin
        mem_ack_i    = 1'b1;
        bfm_ack_pend = 1'b0;
`ifdef STORE_BUS_ERR_EN
        mem_err_i = err_force;
`endif
      end else begin
        bfm_ack_cnt++;
      end
    end else if (mem_req_o) begin
      if (bfm_req_cnt >= gnt_dly) begin
        mem_gnt_i   = 1'b1;
        bfm_req_cnt = 0;
        if (ack_dly == 0) begin
          mem_ack_i = 1'b1;
`ifdef STORE_BUS_ERR_EN
          mem_err_i = err_force;
`endif
        end else begin
          bfm_ack_pend = 1'b1;
          bfm_ack_cnt  = 1;
        end
      end else begin
        bfm_req_cnt++;
      end
    end
  end

  // ---------------- monitor: pops expectations whenever the DUT presents output
  int              mon_req_cnt = 0;
  logic [PHYS-3:0] m_addr;
  dc_exp_t         m_dc;
  mem_exp_t        m_mem;
  done_exp_t       m_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_req_cnt = 0;
    end else begin
      if (tag_rd_en_o) begin
        if (done_q.size() == 0) fail_event("tag_rd_spurious");
        else if (done_q[0].io) fail_event("tag_rd_on_io");
        else begin
          m_addr = done_q[0].addr;
          check("tag_rd_index", 64'(tag_rd_index_o), 64'(m_addr[8:3]));
        end
      end
      if (dc_wr_en_o) begin
        if (dc_q.size() == 0) fail_event("dc_wr_spurious");
        else begin
          m_dc = dc_q.pop_front();
          check("dc_wr_index", 64'(dc_wr_index_o), 64'(m_dc.idx));
          check("dc_wr_data", 64'(dc_wr_data_o), 64'(m_dc.data));
          check("dc_wr_bm", 64'(dc_wr_bm_o), 64'(m_dc.bm));
        end
      end
      if (mem_req_o) begin
        if (mem_q.size() == 0) fail_event("mem_req_spurious");
        else begin
          m_mem = mem_q[0];
          check("mem_addr", 64'(mem_addr_o), 64'(m_mem.addr));
          check("mem_data", 64'(mem_data_o), 64'(m_mem.data));
          check("mem_bm", 64'(mem_bm_o), 64'(m_mem.bm));
          check("mem_io", 64'(mem_io_o), 64'(m_mem.io));
          mon_req_cnt++;
          if (mem_gnt_i) begin
            if (m_mem.reqc != 0) check("mem_req_cycles", 64'(mon_req_cnt), 64'(m_mem.reqc));
            m_mem = mem_q.pop_front();
            mon_req_cnt = 0;
          end
        end
      end
      if (cache_done_o) begin
        if (done_q.size() == 0) fail_event("done_spurious");
        else begin
          m_done = done_q.pop_front();
          if (m_done.lat != 0) check("done_latency", 64'(cyc - m_done.accept), 64'(m_done.lat));
`ifdef STORE_BUS_ERR_EN
          check("store_fault", 64'(store_fault_o), 64'(m_done.err));
          if (m_done.err) check("store_fault_addr", 64'(store_fault_addr_o), 64'(m_done.addr));
`endif
        end
      end
    end
  end

  // ---------------- stimulus
  // Called at posedge+1 with the DUT in IDLE; expectations are queued before the request.
  task automatic start_store(input logic [PHYS-3:0] a, input logic [31:0] d, input logic [3:0] bm,
                             input logic io, input int lat, input int reqc, input logic err);
    logic [SL-1:0]   set;
    logic [TAGW-1:0] tg;
    logic            hit;
    set = a[8:3];
    tg  = a[PHYS-3:9];
    hit = !io && vld_mem[set] && (tag_mem[set] == tg);
    if (hit) dc_q.push_back('{idx: a[8:0], data: d, bm: bm});
    mem_q.push_back('{addr: a, data: d, bm: bm, io: io, reqc: reqc});
    done_q.push_back('{addr: a, io: io, accept: cyc, lat: lat, err: err});
`ifdef STORE_BUS_ERR_EN
    err_force = err;
`endif
    store_address_i = a;
    store_data_i    = d;
    store_bm_i      = bm;
    store_io_i      = io;
    store_valid_i   = 1'b1;
  endtask

  // Valid stays high through the DONE cycle, then drops; the gap must stay silent.
  task automatic finish_store(input int gap);
    int n;
    n = 0;
    while (!cache_done_o && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cache_done_o) begin
      fail_event("done_timeout");
      dc_q.delete(); mem_q.delete(); done_q.delete();
    end
    @(posedge clk); #1;
    store_valid_i = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done"}, 64'(cache_done_o), 64'd0);
    check({tag, "_tag_rd_en"}, 64'(tag_rd_en_o), 64'd0);
    check({tag, "_dc_wr_en"}, 64'(dc_wr_en_o), 64'd0);
    check({tag, "_mem_req"}, 64'(mem_req_o), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr_o), 64'd0);
    check({tag, "_mem_data"}, 64'(mem_data_o), 64'd0);
    check({tag, "_mem_bm_io"}, 64'({mem_bm_o, mem_io_o}), 64'd0);
    check({tag, "_dc_wr_fields"}, 64'({dc_wr_index_o, dc_wr_bm_o}), 64'd0);
  endtask

  initial begin
    logic [PHYS-3:0] a;
    logic [SL-1:0]   s;
    logic [TAGW-1:0] t;
    logic            io, err;
    logic [3:0]      bm;

    for (int i = 0; i < 64; i++) begin
      tag_mem[i] = TAGW'($urandom);
      vld_mem[i] = ($urandom_range(0, 3) != 0);
    end
    vld_mem[5] = 1'b1;
    vld_mem[9] = 1'b1;
    vld_mem[7] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // IO store, immediate grant+ack
    gnt_dly = 0; ack_dly = 0;
    start_store(30'h100, 32'h1234_5678, 4'hF, 1'b1, 2, 1, 1'b0);
    finish_store(2);

    // Cacheable hit
    a = {tag_mem[5], 6'd5, 3'd2};
    start_store(a, 32'hDEAD_BEEF, 4'b0011, 1'b0, 4, 1, 1'b0);
    finish_store(2);

    // Cacheable miss (line invalid)
    a = {TAGW'($urandom), 6'd7, 3'd1};
    start_store(a, 32'hCAFE_F00D, 4'b1100, 1'b0, 4, 1, 1'b0);
    finish_store(2);

    // Zero byte mask on a hit: full flow, zero masks
    a = {tag_mem[5], 6'd5, 3'd7};
    start_store(a, 32'h0BAD_0BAD, 4'b0000, 1'b0, 4, 1, 1'b0);
    finish_store(2);

    // Refill engine holds the arrays for 3 TAGRD cycles
    a = {tag_mem[9], 6'd9, 3'd4};
    busy_force = 1'b1;
    start_store(a, 32'h5555_AAAA, 4'b1010, 1'b0, 7, 1, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    busy_force = 1'b0;
    finish_store(2);

    // Slow bus: grant after 5 wait cycles, ack 2 cycles after grant
    gnt_dly = 5; ack_dly = 2;
    start_store(30'h2A5, 32'h0F0F_1234, 4'b0110, 1'b1, 9, 6, 1'b0);
    finish_store(6);

    // Reset while waiting for the ack
    gnt_dly = 0; ack_dly = 10;
    start_store(30'h40, 32'h7777_8888, 4'hF, 1'b1, 0, 1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    store_valid_i = 1'b0;
    done_q.delete(); mem_q.delete(); dc_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ack_dly = 0;
    a = {tag_mem[9], 6'd9, 3'd0};
    start_store(a, 32'h1357_9BDF, 4'b1111, 1'b0, 4, 1, 1'b0);
    finish_store(2);

`ifdef STORE_BUS_ERR_EN
    start_store(30'h3ABC, 32'hE5E5_E5E5, 4'hF, 1'b1, 2, 1, 1'b1);
    finish_store(2);
    start_store(30'h1111, 32'h0000_0001, 4'h1, 1'b1, 2, 1, 1'b0);
    finish_store(2);
    check("fault_addr_held", 64'(store_fault_addr_o), 64'(30'h3ABC));
`endif

    // Randomized traffic with random stalls and bus delays
    busy_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      gnt_dly = $urandom_range(0, 3);
      ack_dly = $urandom_range(0, 3);
      io  = ($urandom_range(0, 3) == 0);
      s   = SL'($urandom);
      t   = ($urandom_range(0, 1) == 1) ? tag_mem[s] : TAGW'($urandom);
      a   = {t, s, 3'($urandom)};
      bm  = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
`ifdef STORE_BUS_ERR_EN
      err = ($urandom_range(0, 3) == 0);
`else
      err = 1'b0;
`endif
      start_store(a, $urandom, bm, io, 0, 0, err);
      finish_store($urandom_range(1, 2));
    end
    busy_rand = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    check("dc_q_drained", 64'(dc_q.size()), 64'd0);
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
    check("done_q_drained", 64'(done_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
